mem_stage: RTL

//  MEM stage of the 5-stage RV32I pipeline, directly downstream of execute.

---
 rtl/mem_stage_pkg.sv | 79 +++++++
 rtl/mem_stage_load_align.sv | 24 ++
 rtl/mem_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared RV32I pipeline types for the MEM stage
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } mem_state_t;

    typedef enum logic [1:0] {
        FWD_ALU,
        FWD_CMP,
        FWD_UIMM
    } fwd_sel_t;

    typedef struct packed {
        logic       regf_we;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        fwd_sel_t   fwd_sel;
    } ctrl_wd_t;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        ctrl_wd_t    ctrl_wd;
        logic [31:0] alu_out;
        logic [31:0] mar;
        logic [31:0] mem_data_out;
        logic [31:0] u_imm;
        logic [4:0]  rd;
        logic        cmp_out;
        rvfi_t       rvfi_d;
    } EX_MEM_stage_t;

    typedef struct packed {
        ctrl_wd_t    ctrl_wd;
        logic [31:0] alu_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [31:0] load_data;
        logic [4:0]  rd;
        rvfi_t       rvfi_d;
    } MEM_WB_stage_t;

    // size is funct3[1:0]: 0 byte, 1 half, otherwise word
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - lane select and sign/zero extension of load data
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o
);

    logic [15:0] shifted;

    always_comb begin
        shifted = 16'(rdata_i >> {off_i, 3'b000});
        case (load_funct3_t'(funct3_i))
            LD_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LD_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LD_LBU:  load_data_o = {24'b0, shifted[7:0]};
            LD_LHU:  load_data_o = {16'b0, shifted[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: D-cache handshake, load align, MEM/WB register
// Optional MEM_RVFI_EN: fill rvfi_d memory fields at commit.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  EX_MEM_stage_t ex_mem_in,
    input  logic          ex_mem_valid,
    input  logic          stall_in,
    output logic [31:0]   dmem_address,
    output logic          dmem_read,
    output logic          dmem_write,
    output logic [3:0]    dmem_mbe,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic          mem_stall,
    output logic [31:0]   ex_mem_rd_data,
    output MEM_WB_stage_t mem_wb_out,
    output logic          mem_wb_valid
);

    mem_state_t    state_q, state_d;
    logic [31:0]   hold_rdata_q, hold_rdata_d;
    MEM_WB_stage_t mem_wb_d;
    logic          mem_wb_valid_d;
    logic          mem_op, req_active, commit, hold_capture;
    logic [1:0]    off;
    logic [31:0]   rdata_src, load_data;

    assign mem_op       = ex_mem_valid & (ex_mem_in.ctrl_wd.mem_read | ex_mem_in.ctrl_wd.mem_write);
    assign off          = ex_mem_in.mar[1:0];
    // Reset kills the request combinationally; the D-cache tolerates an abandoned access.
    assign req_active   = mem_op & (state_q != HOLD) & ~rst;
    assign dmem_address = {ex_mem_in.mar[31:2], 2'b00};
    assign dmem_read    = req_active & ex_mem_in.ctrl_wd.mem_read;
    assign dmem_write   = req_active & ex_mem_in.ctrl_wd.mem_write;
    assign dmem_mbe     = (ex_mem_valid & ex_mem_in.ctrl_wd.mem_write)
                          ? byte_mask(ex_mem_in.ctrl_wd.funct3[1:0], off) : 4'b0000;
    assign dmem_wdata   = ex_mem_in.mem_data_out;
    assign mem_stall    = mem_op & (state_q != HOLD) & ~dmem_resp;
    assign commit       = ~mem_stall & ~stall_in;
    assign hold_capture = mem_op & (state_q != HOLD) & dmem_resp & stall_in;
    assign rdata_src    = (state_q == HOLD) ? hold_rdata_q : dmem_rdata;

    load_align u_load_align (
        .rdata_i     (rdata_src),
        .off_i       (off),
        .funct3_i    (ex_mem_in.ctrl_wd.funct3),
        .load_data_o (load_data)
    );

    always_comb begin
        case (ex_mem_in.ctrl_wd.fwd_sel)
            FWD_CMP:  ex_mem_rd_data = {31'b0, ex_mem_in.cmp_out};
            FWD_UIMM: ex_mem_rd_data = ex_mem_in.u_imm;
            default:  ex_mem_rd_data = ex_mem_in.alu_out;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hold_rdata_d = hold_rdata_q;
        if (hold_capture) hold_rdata_d = dmem_rdata;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (!dmem_resp)    state_d = WAIT;
                    else if (stall_in) state_d = HOLD;
                end
            end
            WAIT: begin
                if (!mem_op)        state_d = IDLE;
                else if (dmem_resp) state_d = stall_in ? HOLD : IDLE;
            end
            HOLD: begin
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_wb_d       = mem_wb_out;
        mem_wb_valid_d = mem_wb_valid;
        if (commit) begin
            mem_wb_d.ctrl_wd   = ex_mem_in.ctrl_wd;
            mem_wb_d.alu_out   = ex_mem_in.alu_out;
            mem_wb_d.cmp_out   = ex_mem_in.cmp_out;
            mem_wb_d.u_imm     = ex_mem_in.u_imm;
            mem_wb_d.load_data = load_data;
            mem_wb_d.rd        = ex_mem_in.rd;
            mem_wb_d.rvfi_d    = ex_mem_in.rvfi_d;
`ifdef MEM_RVFI_EN
            mem_wb_d.rvfi_d.mem_addr  = dmem_address;
            mem_wb_d.rvfi_d.mem_rmask = (mem_op & ex_mem_in.ctrl_wd.mem_read)
                                        ? byte_mask(ex_mem_in.ctrl_wd.funct3[1:0], off) : 4'b0000;
            mem_wb_d.rvfi_d.mem_wmask = dmem_mbe;
            mem_wb_d.rvfi_d.mem_rdata = rdata_src;
            mem_wb_d.rvfi_d.mem_wdata = dmem_wdata;
`endif
            mem_wb_valid_d     = ex_mem_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_rdata_q <= '0;
            mem_wb_out   <= '0;
            mem_wb_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_rdata_q <= hold_rdata_d;
            mem_wb_out   <= mem_wb_d;
            mem_wb_valid <= mem_wb_valid_d;
        end
    end

endmodule
